// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - size encodings, FSM states and byte-lane helpers for dmem_resp
package dmem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data so every candidate lane carries it; the mask picks.
  function automatic logic [31:0] lane_place(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: lane_place = {4{wdata[7:0]}};
      SZ_HALF: lane_place = {2{wdata[15:0]}};
      default: lane_place = wdata;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: lane_extract = {{24{~uns & b[7]}}, b};
      SZ_HALF: lane_extract = {{16{~uns & h[15]}}, h};
      SZ_WORD: lane_extract = word;
      default: lane_extract = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_resp_bank.sv
// rtl/dmem_resp_bank.sv - word storage with byte-enable synchronous write, combinational read
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - load/store responder: capture, optional wait states, single access, held response
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        h_we, h_uns;
  logic [1:0]  h_size;
  logic [11:0] h_addr;
  logic [31:0] h_wdata;

  logic        accept, req_err, access;
  logic        a_we, a_uns;
  logic [1:0]  a_size;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] bank_rdata;
  logic        bank_we;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_err = misaligned(req_size, req_addr[1:0]);

  // With no wait states the access happens on the accept edge, so it must use the live request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      a_we = req_we; a_uns = req_uns; a_size = req_size; a_addr = req_addr; a_wdata = req_wdata;
    end else begin
      a_we = h_we;   a_uns = h_uns;   a_size = h_size;   a_addr = h_addr;   a_wdata = h_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (access) begin
      err_d   = 1'b0;
      rdata_d = a_we ? 32'd0 : lane_extract(bank_rdata, a_size, a_addr[1:0], a_uns);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      h_we    <= 1'b0;
      h_uns   <= 1'b0;
      h_size  <= 2'b00;
      h_addr  <= 12'd0;
      h_wdata <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        h_we    <= req_we;
        h_uns   <= req_uns;
        h_size  <= req_size;
        h_addr  <= req_addr;
        h_wdata <= req_wdata;
      end
    end
  end

  // Reset gates the write so an abandoned store can never land.
  assign bank_we = access && a_we && !rst;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .be   (lane_mask(a_size, a_addr[1:0])),
    .addr (a_addr[AW+1:2]),
    .wdata(lane_place(a_size, a_wdata)),
    .rdata(bank_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed vectors for dmem_resp at WAIT_CYCLES 1, 4 and 0 (256-word)
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  rsp_ready = 3'b111;
  logic        req_we = 1'b0, req_uns = 1'b0;
  logic [1:0]  req_size = SZ_WORD;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata [3];

  dmem_resp #(.WAIT_CYCLES(1), .DEPTH_WORDS(1024)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_resp #(.WAIT_CYCLES(4), .DEPTH_WORDS(1024)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_resp #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  typedef struct {
    int          inst;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input int inst, input logic we, input logic [1:0] size, input logic uns,
                     input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.inst = inst; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  // Issues one request; lat counts clock edges from the accept edge to rsp_valid being seen.
  task automatic do_req(input int i, input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid[i] = 1'b1;
    guard = 0;
    while (!req_ready[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = (guard < 50) ? 1 : 99;
    while (!rsp_valid[i] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[i];
    err   = rsp_err[i];
  endtask

  task automatic b2b(input int i, input int exp_gap);
    int first, second;
    first = -1;
    second = -1;
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_WORD; req_uns = 1'b0; req_addr = 12'h010;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (req_ready[i]) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      @(negedge clk);
    end
    req_valid[i] = 1'b0;
    check($sformatf("b2b_gap_inst%0d", i), 32'(second - first), 32'(exp_gap));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    // inst 0: WAIT_CYCLES=1
    add(0, 1, SZ_WORD, 0, 12'h010, 32'h12345678, 32'h00000000, 0, 2);
    add(0, 0, SZ_WORD, 0, 12'h010, 32'h0,        32'h12345678, 0, 2);
    add(0, 1, SZ_BYTE, 0, 12'h013, 32'h000000AB, 32'h00000000, 0, 2);
    add(0, 0, SZ_BYTE, 0, 12'h013, 32'h0,        32'hFFFFFFAB, 0, 2);
    add(0, 0, SZ_BYTE, 1, 12'h013, 32'h0,        32'h000000AB, 0, 2);
    add(0, 0, SZ_WORD, 0, 12'h010, 32'h0,        32'hAB345678, 0, 2);
    add(0, 1, SZ_WORD, 0, 12'h020, 32'h00000000, 32'h00000000, 0, 2);
    add(0, 1, SZ_HALF, 0, 12'h022, 32'h00008001, 32'h00000000, 0, 2);
    add(0, 0, SZ_HALF, 0, 12'h022, 32'h0,        32'hFFFF8001, 0, 2);
    add(0, 0, SZ_WORD, 0, 12'h021, 32'h0,        32'h00000000, 1, 1);
    add(0, 0, SZ_WORD, 0, 12'h020, 32'h0,        32'h80010000, 0, 2);
    add(0, 0, SZ_HALF, 1, 12'h022, 32'h0,        32'h00008001, 0, 2);
    add(0, 0, SZ_BYTE, 0, 12'h023, 32'h0,        32'hFFFFFF80, 0, 2);
    add(0, 1, SZ_HALF, 0, 12'h023, 32'h0000FFFF, 32'h00000000, 1, 1);
    add(0, 1, SZ_WORD, 0, 12'h012, 32'hFFFFFFFF, 32'h00000000, 1, 1);
    add(0, 0, SZ_RSVD, 0, 12'h010, 32'h0,        32'h00000000, 1, 1);
    add(0, 0, SZ_WORD, 0, 12'h010, 32'h0,        32'hAB345678, 0, 2);
    add(0, 0, SZ_WORD, 0, 12'h020, 32'h0,        32'h80010000, 0, 2);
    add(0, 0, SZ_HALF, 0, 12'h010, 32'h0,        32'h00005678, 0, 2);
    add(0, 0, SZ_HALF, 0, 12'h012, 32'h0,        32'hFFFFAB34, 0, 2);
    add(0, 0, SZ_HALF, 1, 12'h012, 32'h0,        32'h0000AB34, 0, 2);
    // inst 2: WAIT_CYCLES=0, 256 words (wraps every 0x400 bytes)
    add(2, 1, SZ_WORD, 0, 12'hFFC, 32'hCAFEF00D, 32'h00000000, 0, 1);
    add(2, 0, SZ_WORD, 0, 12'hFFC, 32'h0,        32'hCAFEF00D, 0, 1);
    add(2, 1, SZ_WORD, 0, 12'h004, 32'h5A5A1234, 32'h00000000, 0, 1);
    add(2, 0, SZ_WORD, 0, 12'h404, 32'h0,        32'h5A5A1234, 0, 1);
    add(2, 1, SZ_BYTE, 0, 12'h405, 32'h00000077, 32'h00000000, 0, 1);
    add(2, 0, SZ_WORD, 0, 12'h004, 32'h0,        32'h5A5A7734, 0, 1);
    add(2, 0, SZ_HALF, 1, 12'h006, 32'h0,        32'h00005A5A, 0, 1);
    add(2, 0, SZ_BYTE, 0, 12'h007, 32'h0,        32'h0000005A, 0, 1);
    add(2, 0, SZ_WORD, 0, 12'h3FC, 32'h0,        32'hCAFEF00D, 0, 1);
    add(2, 0, SZ_HALF, 0, 12'h001, 32'h0,        32'h00000000, 1, 1);
    // inst 1: WAIT_CYCLES=4, prior contents for the reset test
    add(1, 1, SZ_WORD, 0, 12'h040, 32'h11111111, 32'h00000000, 0, 5);
    add(1, 0, SZ_WORD, 0, 12'h040, 32'h0,        32'h11111111, 0, 5);

    #2 rst = 1'b1;
    #1;
    check("reset_req_ready", {29'd0, req_ready}, 32'h7);
    check("reset_rsp_valid", {29'd0, rsp_valid}, 32'h0);
    check("reset_rsp_err",   {29'd0, rsp_err},   32'h0);
    check("reset_rsp_rdata0", rsp_rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      do_req(vecs[k].inst, vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
             rd, er, lat);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      check($sformatf("vec%0d_err", k), {31'd0, er}, {31'd0, vecs[k].exp_err});
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
    end

    // Response held while rsp_ready is low
    rsp_ready[0] = 1'b0;
    do_req(0, 0, SZ_WORD, 0, 12'h010, 32'h0, rd, er, lat);
    check("hold_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_valid_ready", c), {30'd0, rsp_valid[0], req_ready[0]}, 32'h2);
      check($sformatf("hold%0d_rdata", c), rsp_rdata[0], 32'hAB345678);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("hold_release_idle", {30'd0, rsp_valid[0], req_ready[0]}, 32'h1);

    // Back-to-back spacing is WAIT_CYCLES+2
    b2b(0, 3);
    b2b(2, 2);
    b2b(1, 6);

    // Reset during the wait states of a store abandons it
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_WORD; req_uns = 1'b0; req_addr = 12'h040; req_wdata = 32'hDEADBEEF;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("abort_in_wait", {30'd0, rsp_valid[1], req_ready[1]}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_req_ready", {31'd0, req_ready[1]}, 32'h1);
    check("abort_rsp_valid", {31'd0, rsp_valid[1]}, 32'h0);
    check("abort_rsp_rdata", rsp_rdata[1], 32'h0);
    check("abort_rsp_err",   {31'd0, rsp_err[1]}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 0, SZ_WORD, 0, 12'h040, 32'h0, rd, er, lat);
    check("abort_mem_kept", rd, 32'h11111111);
    check("abort_load_latency", 32'(lat), 32'd5);
    do_req(0, 0, SZ_WORD, 0, 12'h010, 32'h0, rd, er, lat);
    check("post_reset_mem_kept", rd, 32'hAB345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
